// File: rtl/count_window_pkg.sv
// Shared types and default widths for the count-window controller.
package count_window_pkg;

    localparam int unsigned CNT_W_DEF = 6;
    localparam int unsigned DIV_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one tick every (div+1) cycles; the phase restarts on clr.
module tick_prescaler
    import count_window_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt_q;

    // The tick stays combinational so the controller can act on it in the same cycle.
    assign tick_c = en & (cnt_q == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/count_window_ctrl.sv
// Runs one parity-classified tick-count window per command and returns
// the even/odd totals through a valid/ready result port.
module count_window_ctrl
    import count_window_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_even,
    output logic [CNT_W-1:0] res_odd,
    output logic             res_aborted
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] even_q, even_d;
    logic [CNT_W-1:0] odd_q, odd_d;
    logic [CNT_W-1:0] res_even_d, res_odd_d;
    logic             res_aborted_d;
    logic             cmd_ready_d, busy_d, res_valid_d;
    logic             accept;
    logic             run;
    logic             tick_c;
    logic             last_tick;

    assign accept    = cmd_valid & cmd_ready;
    assign run       = (state_q == ST_RUN);
    assign last_tick = (idx_q == len_q - CNT_W'(1));

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     (run),
        .div    (div_q),
        .tick_c (tick_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        div_d         = div_q;
        idx_d         = idx_q;
        even_d        = even_q;
        odd_d         = odd_q;
        res_even_d    = res_even;
        res_odd_d     = res_odd;
        res_aborted_d = res_aborted;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    len_d         = cmd_len;
                    div_d         = cmd_div;
                    idx_d         = '0;
                    even_d        = '0;
                    odd_d         = '0;
                    res_even_d    = '0;
                    res_odd_d     = '0;
                    res_aborted_d = 1'b0;
                    state_d       = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort takes priority, so a coincident tick is dropped.
                if (abort) begin
                    state_d       = ST_DONE;
                    res_even_d    = even_q;
                    res_odd_d     = odd_q;
                    res_aborted_d = 1'b1;
                end else if (tick_c) begin
                    if (idx_q[0]) begin
                        odd_d = odd_q + CNT_W'(1);
                    end else begin
                        even_d = even_q + CNT_W'(1);
                    end
                    idx_d = idx_q + CNT_W'(1);
                    if (last_tick) begin
                        state_d       = ST_DONE;
                        res_even_d    = even_d;
                        res_odd_d     = odd_d;
                        res_aborted_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d       = ST_IDLE;
                    res_even_d    = '0;
                    res_odd_d     = '0;
                    res_aborted_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            div_q       <= '0;
            idx_q       <= '0;
            even_q      <= '0;
            odd_q       <= '0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_even    <= '0;
            res_odd     <= '0;
            res_aborted <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            even_q      <= even_d;
            odd_q       <= odd_d;
            cmd_ready   <= cmd_ready_d;
            busy        <= busy_d;
            res_valid   <= res_valid_d;
            res_even    <= res_even_d;
            res_odd     <= res_odd_d;
            res_aborted <= res_aborted_d;
        end
    end

endmodule

// File: tb/tb_count_window_ctrl.sv
// Scoreboard bench: the driver queues hand-computed results, a monitor pops and compares them.
module tb_count_window_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [5:0] cmd_len = '0;
    logic [3:0] cmd_div = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [5:0] res_even;
    logic [5:0] res_odd;
    logic       res_aborted;

    typedef struct {
        int even;
        int odd;
        int aborted;
        int edge_at;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [5:0] pe = '0;
    logic [5:0] po = '0;
    logic       pa = 1'b0;

    count_window_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_div     (cmd_div),
        .abort       (abort),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_even    (res_even),
        .res_odd     (res_odd),
        .res_aborted (res_aborted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at edge %0d", name, edge_n);
    endtask

    // Offer a command; returns the edge number at which it was accepted.
    task automatic send(input int len, input int div, output int ea);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) timeout("cmd_ready_wait");
        cmd_valid = 1'b1;
        cmd_len   = 6'(len);
        cmd_div   = 4'(div);
        @(posedge clk); #1;
        ea        = edge_n;
        cmd_valid = 1'b0;
    endtask

    task automatic expect_res(input int even, input int odd, input int ab, input int edge_at);
        exp_t e;
        e.even = even; e.odd = odd; e.aborted = ab; e.edge_at = edge_at;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready === 1'b1 && busy === 1'b0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) timeout("idle_wait");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (res_valid !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) timeout("res_valid_wait");
    endtask

    // Monitor: compares each new result and holds it stable while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("stall_valid", 32'(res_valid), 32'd1);
                    check("stall_even", 32'(res_even), 32'(pe));
                    check("stall_odd", 32'(res_odd), 32'(po));
                    check("stall_aborted", 32'(res_aborted), 32'(pa));
                end else if (res_valid) begin
                    if (pv) begin
                        timeout("res_valid_not_dropped");
                    end else if (exp_q.size() == 0) begin
                        timeout("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        check("res_even", 32'(res_even), 32'(e.even));
                        check("res_odd", 32'(res_odd), 32'(e.odd));
                        check("res_aborted", 32'(res_aborted), 32'(e.aborted));
                        check("res_latency_edge", 32'(edge_n), 32'(e.edge_at));
                    end
                end
                pv = res_valid;
                pr = res_ready;
                pe = res_even;
                po = res_odd;
                pa = res_aborted;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Driver.
    initial begin
        int ea;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("release_cmd_ready_high", 32'(cmd_ready), 32'd1);

        // Abort while idle has no effect.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_ready", 32'(cmd_ready), 32'd1);

        send(6, 0, ea);
        expect_res(3, 3, 0, ea + 6);
        wait_idle();

        send(5, 2, ea);
        expect_res(3, 2, 0, ea + 15);
        check("run_busy", 32'(busy), 32'd1);
        check("run_cmd_ready", 32'(cmd_ready), 32'd0);
        wait_idle();

        check("pre_len0_busy", 32'(busy), 32'd0);
        send(0, 7, ea);
        expect_res(0, 0, 0, ea);
        check("len0_busy_t1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("len0_busy_after_hs", 32'(busy), 32'd0);
        check("len0_ready_after_hs", 32'(cmd_ready), 32'd1);

        send(10, 1, ea);
        expect_res(2, 1, 1, ea + 8);
        repeat (7) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle();

        // Stalled result: stays put, no new command accepted, abort ignored.
        res_ready = 1'b0;
        send(3, 0, ea);
        expect_res(2, 1, 0, ea + 3);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            cmd_len   = 6'd5;
            abort     = (i == 5);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_res_valid", 32'(res_valid), 32'd0);
        check("hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check("hs_res_even", 32'(res_even), 32'd0);
        check("hs_res_odd", 32'(res_odd), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);

        send(1, 3, ea);
        expect_res(1, 0, 0, ea + 4);
        wait_idle();

        // Reset mid-window discards the run.
        send(63, 15, ea);
        expect_res(32, 31, 0, ea + 1008);
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_res_valid", 32'(res_valid), 32'd0);
        check("async_rst_res_even", 32'(res_even), 32'd0);
        check("async_rst_res_odd", 32'(res_odd), 32'd0);
        check("async_rst_res_aborted", 32'(res_aborted), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerelease_cmd_ready", 32'(cmd_ready), 32'd1);

        send(2, 1, ea);
        expect_res(1, 1, 0, ea + 4);
        wait_idle();

        send(63, 15, ea);
        expect_res(32, 31, 0, ea + 1008);
        wait_idle();

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
